// File: rtl/imm_decode_pkg.sv
// Shared types and constants for the immediate-decode pipeline stage.
package imm_decode_pkg;

  // Immediate format classes reported alongside each decoded instruction.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_CSR  = 3'd6
  } imm_type_e;

  // Skid-buffer occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

  // RV32 major opcodes recognised by the immediate generator.
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] OP     = 7'b0110011;

  // Everything execute needs from one instruction, except the PC, whose
  // width is a parameter of the stage and is therefore stored beside it.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    imm_type_e   imm_type;
    logic        illegal;
  } decoded_bundle_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: classifies the immediate format of an
// RV32 instruction and produces the 32-bit extended value.
module imm_gen
  import imm_decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output imm_type_e   imm_type,
  output logic        illegal
);

  // Opcode-driven format select; unknown opcodes yield a zero immediate.
  always_comb begin
    imm      = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (instr[6:0])
      OP_IMM: begin
        imm_type = IMM_I;
        // Shift-immediates carry an unsigned 5-bit shamt; funct7 stays in
        // its own field so srai/srli remain distinguishable.
        if (instr[13:12] == 2'b01) imm = {27'b0, instr[24:20]};
        else                       imm = {{20{instr[31]}}, instr[31:20]};
      end
      LOAD, JALR: begin
        imm_type = IMM_I;
        imm      = {{20{instr[31]}}, instr[31:20]};
      end
      STORE: begin
        imm_type = IMM_S;
        imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      BRANCH: begin
        imm_type = IMM_B;
        imm      = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        imm_type = IMM_U;
        imm      = {instr[31:12], 12'b0};
      end
      JAL: begin
        imm_type = IMM_J;
        imm      = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      SYSTEM: begin
        // Only the immediate CSR forms (funct3[2]=1) carry a uimm in rs1.
        if (instr[14]) begin
          imm_type = IMM_CSR;
          imm      = {27'b0, instr[19:15]};
        end
      end
      OP: begin
        imm_type = IMM_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode pipeline stage: splits instructions into fields, generates the
// immediate, and hands bundles to execute through a 2-entry skid buffer.
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [31:0]     out_imm,
  output logic [2:0]      out_imm_type,
  output logic            out_illegal
);

  occ_state_e      state_reg, state_next;
  decoded_bundle_t out_bundle_reg, out_bundle_next;
  decoded_bundle_t skid_bundle_reg, skid_bundle_next;
  logic [XLEN-1:0] out_pc_reg, out_pc_next;
  logic [XLEN-1:0] skid_pc_reg, skid_pc_next;
  logic            in_ready_reg;
  logic            accept;

  decoded_bundle_t dec_bundle;
  logic [31:0]     dec_imm;
  imm_type_e       dec_imm_type;
  logic            dec_illegal;

  imm_gen u_imm_gen (
    .instr    (in_instr),
    .imm      (dec_imm),
    .imm_type (dec_imm_type),
    .illegal  (dec_illegal)
  );

  // Field split of the incoming instruction into a bundle.
  always_comb begin
    dec_bundle          = '0;
    dec_bundle.opcode   = in_instr[6:0];
    dec_bundle.rd       = in_instr[11:7];
    dec_bundle.funct3   = in_instr[14:12];
    dec_bundle.rs1      = in_instr[19:15];
    dec_bundle.rs2      = in_instr[24:20];
    dec_bundle.funct7   = in_instr[31:25];
    dec_bundle.imm      = dec_imm;
    dec_bundle.imm_type = dec_imm_type;
    dec_bundle.illegal  = dec_illegal;
  end

  assign accept = in_valid & in_ready_reg;

  // Occupancy FSM and data movement between input, output and skid entries.
  always_comb begin
    state_next       = state_reg;
    out_bundle_next  = out_bundle_reg;
    out_pc_next      = out_pc_reg;
    skid_bundle_next = skid_bundle_reg;
    skid_pc_next     = skid_pc_reg;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            out_bundle_next = dec_bundle;
            out_pc_next     = in_pc;
            state_next      = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && out_ready) begin
            out_bundle_next = dec_bundle;
            out_pc_next     = in_pc;
          end else if (accept) begin
            skid_bundle_next = dec_bundle;
            skid_pc_next     = in_pc;
            state_next       = ST_TWO;
          end else if (out_ready) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain path can fire.
          if (out_ready) begin
            out_bundle_next = skid_bundle_reg;
            out_pc_next     = skid_pc_reg;
            state_next      = ST_ONE;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // State and storage registers; in_ready is registered from the next state
  // so it never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_EMPTY;
      out_bundle_reg  <= '0;
      skid_bundle_reg <= '0;
      out_pc_reg      <= RESET_PC_TAG;
      skid_pc_reg     <= RESET_PC_TAG;
      in_ready_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      out_bundle_reg  <= out_bundle_next;
      skid_bundle_reg <= skid_bundle_next;
      out_pc_reg      <= out_pc_next;
      skid_pc_reg     <= skid_pc_next;
      in_ready_reg    <= (state_next != ST_TWO);
    end
  end

  assign in_ready     = in_ready_reg;
  assign out_valid    = (state_reg != ST_EMPTY);
  assign out_pc       = out_pc_reg;
  assign out_opcode   = out_bundle_reg.opcode;
  assign out_rd       = out_bundle_reg.rd;
  assign out_rs1      = out_bundle_reg.rs1;
  assign out_rs2      = out_bundle_reg.rs2;
  assign out_funct3   = out_bundle_reg.funct3;
  assign out_funct7   = out_bundle_reg.funct7;
  assign out_imm      = out_bundle_reg.imm;
  assign out_imm_type = out_bundle_reg.imm_type;
  assign out_illegal  = out_bundle_reg.illegal;

endmodule
